// File: rtl/serial_uart_bridge.sv
// Device-side UART endpoint for the processor serial port: 8N1 receiver and
// transmitter, each buffered by a first-word-fall-through FIFO.
module serial_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] serial_data_out,
  output logic       serial_valid_out,
  input  logic       serial_rden_in,
  output logic       serial_ready_out,
  input  logic [7:0] serial_data_in,
  input  logic       serial_wren_in,
  input  logic       err_clr_in,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out,
  output logic       tx_drop_out,
  output logic       tx_busy_out
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ---------------------------------------------------------------- RX path
  logic               rx_meta, rx_sync, rx_prev;
  logic [1:0]         rx_state;
  logic [CNT_W-1:0]   rx_cnt;
  logic [2:0]         rx_bit;
  logic [7:0]         rx_shift;
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [FIFO_AW:0]   rx_count;
  logic               rx_full, rx_pop, rx_push, rx_push_ok, rx_bad_stop;

  assign rx_full     = (rx_count == COUNT_FULL);
  assign rx_pop      = serial_rden_in && (rx_count != '0);
  assign rx_push     = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && rx_sync;
  assign rx_bad_stop = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && !rx_sync;
  assign rx_push_ok  = rx_push && (!rx_full || rx_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= ST_START;
            rx_cnt   <= '0;
          end
        end
        ST_START: begin
          // Mid-start sample: a high line here means a glitch, not a frame.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) rx_state <= ST_IDLE;
          else                    rx_cnt   <= rx_cnt + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      rx_count <= rx_count + {{FIFO_AW{1'b0}}, rx_push_ok} - {{FIFO_AW{1'b0}}, rx_pop};
    end
  end

  assign serial_valid_out = (rx_count != '0);
  assign serial_data_out  = (rx_count != '0) ? rx_mem[rx_rd_ptr] : '0;

  // ---------------------------------------------------------------- TX path
  logic [1:0]         tx_state;
  logic [CNT_W-1:0]   tx_cnt;
  logic [2:0]         tx_bit;
  logic [7:0]         tx_shift;
  logic               tx_avail;
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [FIFO_AW:0]   tx_count;
  logic               tx_full, tx_pop, tx_push_ok;

  // tx_avail is a registered copy of non-empty, giving the one idle cycle
  // between a write (or a finished stop bit) and the next start bit.
  assign tx_full    = (tx_count == COUNT_FULL);
  assign tx_pop     = (tx_state == ST_IDLE) && tx_avail && (tx_count != '0);
  assign tx_push_ok = serial_wren_in && (!tx_full || tx_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state    <= ST_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_avail    <= 1'b0;
      uart_tx_out <= 1'b1;
    end else begin
      tx_avail <= (tx_count != '0);
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_shift    <= tx_mem[tx_rd_ptr];
            tx_cnt      <= '0;
            tx_state    <= ST_START;
            uart_tx_out <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_state    <= ST_DATA;
            uart_tx_out <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state    <= ST_STOP;
              uart_tx_out <= 1'b1;
            end else begin
              tx_bit      <= tx_bit + 1'b1;
              tx_shift    <= {1'b0, tx_shift[7:1]};
              uart_tx_out <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) tx_state <= ST_IDLE;
          else                    tx_cnt   <= tx_cnt + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push_ok) tx_mem[tx_wr_ptr] <= serial_data_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      tx_count <= tx_count + {{FIFO_AW{1'b0}}, tx_push_ok} - {{FIFO_AW{1'b0}}, tx_pop};
    end
  end

  assign serial_ready_out = !tx_full;
  assign tx_busy_out      = (tx_state != ST_IDLE);

  // ---------------------------------------------------------- sticky errors
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
      tx_drop_out      <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop)           rx_overrun_out <= 1'b1;
      else if (err_clr_in)                         rx_overrun_out <= 1'b0;
      if (rx_bad_stop)                             rx_frame_err_out <= 1'b1;
      else if (err_clr_in)                         rx_frame_err_out <= 1'b0;
      if (serial_wren_in && tx_full && !tx_pop)    tx_drop_out <= 1'b1;
      else if (err_clr_in)                         tx_drop_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Self-checking bench for serial_uart_bridge at CLKS_PER_BIT=4: directed
// scenarios plus random byte streams, checked against queue-based models.
module tb_serial_uart_bridge;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx_in = 1'b1;
  logic       uart_tx_out;
  logic [7:0] serial_data_out;
  logic       serial_valid_out;
  logic       serial_rden_in = 1'b0;
  logic       serial_ready_out;
  logic [7:0] serial_data_in = '0;
  logic       serial_wren_in = 1'b0;
  logic       err_clr_in = 1'b0;
  logic       rx_overrun_out, rx_frame_err_out, tx_drop_out, tx_busy_out;

  serial_uart_bridge #(.CLKS_PER_BIT(4), .FIFO_AW(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .serial_data_out  (serial_data_out),
    .serial_valid_out (serial_valid_out),
    .serial_rden_in   (serial_rden_in),
    .serial_ready_out (serial_ready_out),
    .serial_data_in   (serial_data_in),
    .serial_wren_in   (serial_wren_in),
    .err_clr_in       (err_clr_in),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out),
    .tx_drop_out      (tx_drop_out),
    .tx_busy_out      (tx_busy_out)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_model[$];   // bytes the RX FIFO should hold, head first
  logic       ov_exp, fe_exp;
  logic [8:0] tx_seen[$];    // {stop bit, byte} decoded from uart_tx_out

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Line-level decoder: mid-bit sampling of each 8N1 frame.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clock); #1;
      if (reset && uart_tx_out == 1'b0) begin
        repeat (2) @(posedge clock);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(posedge clock);
          #1 b[k] = uart_tx_out;
        end
        repeat (4) @(posedge clock);
        #1 tx_seen.push_back({uart_tx_out, b});
      end
    end
  end

  // Drives one frame; serial_rden_in pulses during slot pop_t (-1 for none).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_t);
    for (int t = 0; t < 44; t++) begin
      if (t < 4)       uart_rx_in = 1'b0;
      else if (t < 36) uart_rx_in = b[(t - 4) / 4];
      else if (t < 40) uart_rx_in = stop;
      else             uart_rx_in = 1'b1;
      serial_rden_in = (t == pop_t);
      tick();
    end
    serial_rden_in = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic popped);
    if (popped && rx_model.size() > 0) void'(rx_model.pop_front());
    if (!stop)                   fe_exp = 1'b1;
    else if (rx_model.size() < 8) rx_model.push_back(b);
    else                         ov_exp = 1'b1;
  endtask

  task automatic drain_rx();
    while (rx_model.size() > 0) begin
      logic [7:0] e;
      e = rx_model.pop_front();
      check("rx_valid", 32'(serial_valid_out), 32'd1);
      check("rx_data", 32'(serial_data_out), 32'(e));
      serial_rden_in = 1'b1;
      tick();
      serial_rden_in = 1'b0;
    end
    check("rx_empty_valid", 32'(serial_valid_out), 32'd0);
    check("rx_empty_data", 32'(serial_data_out), 32'd0);
  endtask

  task automatic clear_errors();
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
    ov_exp = 1'b0;
    fe_exp = 1'b0;
    check("clr_overrun", 32'(rx_overrun_out), 32'd0);
    check("clr_frame", 32'(rx_frame_err_out), 32'd0);
    check("clr_drop", 32'(tx_drop_out), 32'd0);
  endtask

  task automatic wait_tx_frames(input int n);
    for (int c = 0; c < n * 41 + 60 && tx_seen.size() < n; c++) tick();
    check("tx_frame_count", 32'(tx_seen.size()), 32'(n));
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] sent[$];
    int         lows;

    ov_exp = 1'b0;
    fe_exp = 1'b0;
    repeat (3) tick();
    check("rst_tx", 32'(uart_tx_out), 32'd1);
    check("rst_valid", 32'(serial_valid_out), 32'd0);
    check("rst_ready", 32'(serial_ready_out), 32'd1);
    check("rst_data", 32'(serial_data_out), 32'd0);
    check("rst_busy", 32'(tx_busy_out), 32'd0);
    check("rst_errs", 32'({rx_overrun_out, rx_frame_err_out, tx_drop_out}), 32'd0);
    reset = 1'b1;
    repeat (4) tick();

    // 1. single TX frame with exact cycle timing
    tx_seen.delete();
    serial_wren_in = 1'b1; serial_data_in = 8'h55;
    tick();                                   // edge N
    serial_wren_in = 1'b0;
    tick();                                   // N+1
    check("tx1_idle_line", 32'(uart_tx_out), 32'd1);
    check("tx1_idle_busy", 32'(tx_busy_out), 32'd0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 40; j++) begin
      tick();                                 // N+2+j
      check($sformatf("tx1_bit%0d", j / 4), 32'(uart_tx_out), 32'(frame[j / 4]));
    end
    check("tx1_busy_n41", 32'(tx_busy_out), 32'd1);
    tick();
    check("tx1_busy_n42", 32'(tx_busy_out), 32'd0);
    wait_tx_frames(1);
    if (tx_seen.size() > 0) check("tx1_decoded", 32'(tx_seen[0]), 32'h155);

    // 2. single RX frame
    send_frame(8'hA3, 1'b1, -1); model_frame(8'hA3, 1'b1, 1'b0);
    drain_rx();

    // 3. TX fill and drop
    tx_seen.delete();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx3_ready%0d", i), 32'(serial_ready_out), (i == 9) ? 32'd0 : 32'd1);
      serial_wren_in = 1'b1; serial_data_in = 8'(i);
      tick();
    end
    serial_wren_in = 1'b0;
    check("tx3_drop", 32'(tx_drop_out), 32'd1);
    wait_tx_frames(9);
    for (int i = 0; i < 9 && i < tx_seen.size(); i++)
      check($sformatf("tx3_byte%0d", i), 32'(tx_seen[i]), 32'({1'b1, 8'(i)}));
    repeat (3) tick();
    check("tx3_idle", 32'(tx_busy_out), 32'd0);
    clear_errors();

    // 4. RX overrun
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, -1);
      model_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    end
    check("rx4_overrun", 32'(rx_overrun_out), 32'(ov_exp));
    drain_rx();
    clear_errors();

    // 5a. one-cycle glitch
    uart_rx_in = 1'b0; tick();
    uart_rx_in = 1'b1; repeat (50) tick();
    check("rx5_glitch_valid", 32'(serial_valid_out), 32'd0);
    check("rx5_glitch_err", 32'(rx_frame_err_out), 32'd0);
    // 5b. bad stop bit
    send_frame(8'h3C, 1'b0, -1); model_frame(8'h3C, 1'b0, 1'b0);
    check("rx5_frame_err", 32'(rx_frame_err_out), 32'(fe_exp));
    check("rx5_frame_valid", 32'(serial_valid_out), 32'd0);
    clear_errors();
    // 5c. pop coinciding with a push into a full FIFO
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h60 + 8'(i), 1'b1, -1);
      model_frame(8'h60 + 8'(i), 1'b1, 1'b0);
    end
    send_frame(8'h9E, 1'b1, 40); model_frame(8'h9E, 1'b1, 1'b1);
    check("rx5_no_overrun", 32'(rx_overrun_out), 32'(ov_exp));
    drain_rx();

    // Random RX bursts, sometimes overflowing, with occasional bad stop bits
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(3, 10);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        logic       s;
        b = 8'($urandom);
        s = ($urandom_range(0, 5) != 0);
        send_frame(b, s, -1);
        model_frame(b, s, 1'b0);
      end
      check("rxr_overrun", 32'(rx_overrun_out), 32'(ov_exp));
      check("rxr_frame_err", 32'(rx_frame_err_out), 32'(fe_exp));
      drain_rx();
      clear_errors();
    end

    // Random TX bursts
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 6);
      tx_seen.delete();
      sent.delete();
      for (int i = 0; i < n; i++) begin
        sent.push_back(8'($urandom));
        serial_wren_in = 1'b1; serial_data_in = sent[i];
        tick();
      end
      serial_wren_in = 1'b0;
      wait_tx_frames(n);
      for (int i = 0; i < n && i < tx_seen.size(); i++)
        check("txr_byte", 32'(tx_seen[i]), 32'({1'b1, sent[i]}));
      check("txr_drop", 32'(tx_drop_out), 32'd0);
      repeat (3) tick();
    end

    // 6. reset during data bit 3 of 0xFF with two more bytes queued
    serial_wren_in = 1'b1; serial_data_in = 8'hFF; tick();   // N
    serial_data_in = 8'h11; tick();                           // N+1
    serial_data_in = 8'h22; tick();                           // N+2
    serial_wren_in = 1'b0;
    repeat (16) tick();                                       // N+18
    check("tx6_busy_before", 32'(tx_busy_out), 32'd1);
    reset = 1'b0;
    tick();                                                   // N+19
    check("tx6_line", 32'(uart_tx_out), 32'd1);
    check("tx6_busy", 32'(tx_busy_out), 32'd0);
    check("tx6_ready", 32'(serial_ready_out), 32'd1);
    reset = 1'b1;
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (uart_tx_out == 1'b0 || tx_busy_out) lows++;
    end
    check("tx6_no_more_frames", 32'(lows), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Device-side endpoint of the processor serial IO port; attaches to the data_memory serial_* pins.
- RX path: deserialises bytes from an external UART line into an RX FIFO. The FIFO head is presented as serial data/valid; the processor pops it with serial_rden.
- TX path: the processor pushes bytes with serial_wren while ready is high. Bytes are queued in a TX FIFO and serialised as 8N1 UART frames.
- All logic runs on the posedge of clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (8) for each of RX and TX.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  reset, synchronous, active-low.
- uart_rx_in  in  1  external UART receive line, asynchronous, idle high.
- uart_tx_out  out  1  external UART transmit line, registered, idle high.
- serial_data_out  out  8  RX FIFO head byte; drives processor serial_in.
- serial_valid_out  out  1  RX FIFO not empty; drives processor serial_valid_in.
- serial_rden_in  in  1  pop RX head; from processor serial_rden_out.
- serial_ready_out  out  1  TX FIFO not full; drives processor serial_ready_in.
- serial_data_in  in  8  byte to transmit; from processor serial_out.
- serial_wren_in  in  1  push serial_data_in; from processor serial_wren_out.
- err_clr_in  in  1  clears all sticky error flags.
- rx_overrun_out  out  1  sticky: received byte dropped because RX FIFO was full.
- rx_frame_err_out  out  1  sticky: stop bit sampled low.
- tx_drop_out  out  1  sticky: wren while TX FIFO full.
- tx_busy_out  out  1  TX FSM not in IDLE.

Behaviour:
- Reset (reset==0 at a posedge):
  - uart_tx_out=1; FIFOs emptied; all error flags=0; tx_busy_out=0; both FSMs go to IDLE.
  - serial_valid_out=0; serial_ready_out=1; serial_data_out=8'h00.
  - Reset mid-frame aborts the frame immediately; the partial byte is discarded and no further bits are sent or received.
- FIFOs:
  - Circular buffers with FIFO_AW-bit pointers, wrap mod depth, count width FIFO_AW+1. Memory array is not reset.
  - First-word-fall-through: serial_data_out is the head byte when non-empty, 8'h00 when empty.
  - Push is accepted if not full, or if full with a pop in the same cycle. Pop is ignored when empty.
  - Simultaneous push and pop leaves count unchanged.
- RX path:
  - uart_rx_in passes through a 2-flop synchroniser.
  - FSM IDLE->START on a synchronised falling edge. The bit counter reloads at each bit.
  - START: sample at CLKS_PER_BIT/2. If high, treat as a false start and return to IDLE. If low, go to DATA.
  - DATA: 8 bits, LSB first, each sampled CLKS_PER_BIT after the previous sample.
  - STOP: sample once.
    - High: push the byte; serial_valid_out rises on the next edge.
    - Low: set rx_frame_err_out and discard the byte.
    - Either case returns to IDLE.
  - Push when the FIFO is full with no simultaneous pop: byte lost, rx_overrun_out set.
  - serial_rden_in is a 1-cycle pulse. Each high cycle with valid=1 pops one byte.
- TX path:
  - serial_wren_in high at edge N: byte enters the FIFO if not full (pop rule above); otherwise tx_drop_out is set.
  - FSM states: IDLE -> START -> DATA -> STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, go to START, drive uart_tx_out=0.
  - Timing from idle: wren at edge N, FIFO count=1 after N, pop and tx line low at edge N+2.
  - START lasts CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT each.
  - STOP: line high for CLKS_PER_BIT cycles, then IDLE. Back-to-back frames begin one cycle after STOP ends.
  - Frame length is 10*CLKS_PER_BIT cycles plus one IDLE cycle between frames.
  - tx_busy_out=1 in START/DATA/STOP.
- Errors:
  - Sticky flags clear at the edge where err_clr_in=1.
  - If a set event and a clear occur in the same cycle, set wins.

Test Plan:
All scenarios use CLKS_PER_BIT=4, FIFO_AW=3.
1. TX single: wren with 0x55 at edge N -> uart_tx_out low at edge N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles; tx_busy_out falls at N+42.
2. RX single: drive 8N1 frame 0xA3 on uart_rx_in -> serial_valid_out=1, serial_data_out=0xA3. One rden pulse -> valid=0, data=0x00.
3. TX fill: 10 back-to-back wren of 0x00..0x09 from idle -> ready=0 in the cycle of the 10th write; 0x09 dropped, tx_drop_out=1. Line carries 9 frames 0x00..0x08 in order.
4. RX overrun: 9 frames 0x10..0x18 with no rden -> rden drains 0x10..0x17 in order; rx_overrun_out=1. err_clr_in pulse -> 0.
5. RX errors:
   - 1-cycle low glitch -> no push, no error flag.
   - Frame 0x3C with stop bit 0 -> no push, rx_frame_err_out=1.
   - Simultaneous rden on a full RX FIFO with an incoming byte -> count stays 8, no overrun.
6. Reset mid-TX: assert reset during the DATA bit 3 of 0xFF with 2 bytes queued -> uart_tx_out=1 from that edge, tx_busy_out=0, serial_ready_out=1, and no further frames.
